// File: rtl/mem_access_master.sv
// Memory-stage load/store initiator: converts pipeline enables, byte address
// and store data into a req/ack transaction toward a multi-cycle word memory,
// freezing the pipeline until the access completes or times out.
module mem_access_master #(
  parameter int ADDRESS_LEN = 32,
  parameter int WORD_LEN    = 32,
  parameter int MEM_BASE    = 1024,
  parameter int MEMORY_SIZE = 64,
  parameter int TIMEOUT     = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   MEM_R_EN,
  input  logic                   MEM_W_EN,
  input  logic [ADDRESS_LEN-1:0] ALU_Res,
  input  logic [WORD_LEN-1:0]    Val_Rm,
  output logic                   freeze,
  output logic [WORD_LEN-1:0]    out,
  output logic                   access_err,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [ADDRESS_LEN-3:0] mem_addr,
  output logic [WORD_LEN-1:0]    mem_wdata,
  input  logic                   mem_ack,
  input  logic [WORD_LEN-1:0]    mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t                 state, state_nx;
  logic [7:0]             cnt;
  logic                   tmo_err_q;
  logic [ADDRESS_LEN-1:0] off;
  logic [ADDRESS_LEN-3:0] word_off;
  logic                   any_en;
  logic                   legal;
  logic                   start;
  logic                   tmo;

  // Address decode: offset from base, word-aligned and inside the memory.
  always_comb begin
    off      = ALU_Res - ADDRESS_LEN'(MEM_BASE);
    word_off = off[ADDRESS_LEN-1:2];
    legal    = (off[1:0] == 2'b00) && (word_off < (ADDRESS_LEN-2)'(MEMORY_SIZE));
    any_en   = MEM_R_EN | MEM_W_EN;
    start    = (state == IDLE) && any_en && legal;
    tmo      = (cnt == 8'(TIMEOUT - 1));
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state logic; DONE always returns to IDLE so an instruction never re-issues.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = REQ;
      REQ:     if (mem_ack || tmo) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs: freeze/mem_req come from state and pipeline inputs only, never from mem_ack.
  always_comb begin
    mem_req    = (state == REQ);
    freeze     = rst && (start || (state == REQ));
    access_err = tmo_err_q ||
                 ((state == IDLE) && any_en && (!legal || (MEM_R_EN && MEM_W_EN)));
  end

  // Request capture, timeout counter, load data and registered timeout flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      out       <= '0;
      cnt       <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      tmo_err_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            mem_we    <= MEM_W_EN;
            mem_addr  <= word_off;
            mem_wdata <= Val_Rm;
            cnt       <= '0;
          end
        end
        REQ: begin
          if (mem_ack) begin
            if (!mem_we) out <= mem_rdata;
          end else begin
            cnt <= cnt + 8'd1;
            if (tmo) tmo_err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_master.sv
// Directed bench for mem_access_master: expected requests go into a scoreboard
// queue when an instruction is presented and are popped when mem_req appears.
module tb_mem_access_master;

  localparam int TIMEOUT = 15;

  logic        clk;
  logic        rst;
  logic        MEM_R_EN, MEM_W_EN;
  logic [31:0] ALU_Res, Val_Rm;
  logic        freeze;
  logic [31:0] out;
  logic        access_err;
  logic        mem_req, mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  mem_access_master #(
    .ADDRESS_LEN(32), .WORD_LEN(32), .MEM_BASE(1024), .MEMORY_SIZE(64), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .ALU_Res(ALU_Res), .Val_Rm(Val_Rm), .freeze(freeze), .out(out),
    .access_err(access_err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        we;
    logic [29:0] addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          req_count = 0;
  logic        req_d = 1'b0;
  logic [31:0] exp_out = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count distinct memory transactions (rising edges of mem_req).
  always @(negedge clk) begin
    if (mem_req && !req_d) req_count = req_count + 1;
    req_d = mem_req;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one legal instruction; waits<0 means the memory never acks.
  task automatic access(input logic we, input logic re, input logic [31:0] addr,
                        input logic [31:0] wdata, input int waits, input logic [31:0] rdata);
    exp_t e;
    int   frz;
    logic err_exp;
    e = '{we: 1'b0, addr: '0, wdata: '0};
    @(negedge clk);
    MEM_W_EN = we; MEM_R_EN = re; ALU_Res = addr; Val_Rm = wdata;
    #1;
    chk("idle_freeze", 32'(freeze), 32'd1);
    chk("idle_req", 32'(mem_req), 32'd0);
    chk("idle_err", 32'(access_err), 32'(we & re));
    sb.push_back('{we: we, addr: 30'((addr - 32'd1024) >> 2), wdata: wdata});
    frz = 1;
    for (int c = 0; c < TIMEOUT + 3; c++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (!mem_req) break;
      frz++;
      if (c == 0 && sb.size() > 0) e = sb.pop_front();
      chk("req_freeze", 32'(freeze), 32'd1);
      chk("req_we", 32'(mem_we), 32'(e.we));
      chk("req_addr", 32'(mem_addr), 32'(e.addr));
      chk("req_wdata", mem_wdata, e.wdata);
      if (c == waits) begin
        mem_ack = 1'b1;
        mem_rdata = rdata;
      end
    end
    // DONE cycle
    #1;
    err_exp = (waits < 0);
    if (!we && !err_exp) exp_out = rdata;
    chk("done_req", 32'(mem_req), 32'd0);
    chk("done_freeze", 32'(freeze), 32'd0);
    chk("freeze_cycles", 32'(frz), err_exp ? 32'(TIMEOUT + 1) : 32'(waits + 2));
    chk("done_err", 32'(access_err), 32'(err_exp));
    chk("done_out", out, exp_out);
    MEM_W_EN = 1'b0; MEM_R_EN = 1'b0;
  endtask

  task automatic illegal(input logic [31:0] addr);
    @(negedge clk);
    MEM_R_EN = 1'b1; ALU_Res = addr;
    #1;
    chk("ill_err", 32'(access_err), 32'd1);
    chk("ill_freeze", 32'(freeze), 32'd0);
    chk("ill_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    chk("ill_req_next", 32'(mem_req), 32'd0);
    chk("ill_out", out, exp_out);
    MEM_R_EN = 1'b0;
  endtask

  initial begin
    int base_cnt;
    rst = 1'b0; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; ALU_Res = '0; Val_Rm = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    #12;
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_freeze", 32'(freeze), 32'd0);
    chk("rst_out", out, 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_err", 32'(access_err), 32'd0);
    @(negedge clk); rst = 1'b1;

    // 1: read, ack in first REQ cycle
    access(1'b0, 1'b1, 32'd1032, 32'd0, 0, 32'hDEADBEEF);
    // 2: write, 3 wait cycles
    access(1'b1, 1'b0, 32'd1024, 32'hFFFFFFFB, 3, 32'h0BADF00D);

    // 3: illegal addresses
    base_cnt = req_count;
    illegal(32'd1026);
    illegal(32'd1024 + 32'd256);
    illegal(32'd1000);
    chk("ill_no_txn", 32'(req_count), 32'(base_cnt));

    // 4: timeout
    access(1'b0, 1'b1, 32'd1040, 32'd0, -1, 32'h11111111);
    @(negedge clk);
    chk("tmo_idle_err", 32'(access_err), 32'd0);
    chk("tmo_out_keep", out, 32'hDEADBEEF);

    // 5: back-to-back read then write
    base_cnt = req_count;
    access(1'b0, 1'b1, 32'd1028, 32'd0, 1, 32'h12345678);
    access(1'b1, 1'b0, 32'd1036, 32'hA5A5A5A5, 0, 32'h0);
    @(negedge clk);
    chk("b2b_txns", 32'(req_count), 32'(base_cnt + 2));

    // both enables: treated as write with access_err flagged in IDLE
    access(1'b1, 1'b1, 32'd1044, 32'h00C0FFEE, 2, 32'h0);

    // 6: async reset during REQ wait
    base_cnt = req_count;
    @(negedge clk);
    MEM_R_EN = 1'b1; ALU_Res = 32'd1040;
    repeat (3) @(negedge clk);
    #1;
    chk("pre_rst_req", 32'(mem_req), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("arst_req", 32'(mem_req), 32'd0);
    chk("arst_freeze", 32'(freeze), 32'd0);
    chk("arst_out", out, 32'd0);
    exp_out = '0;
    @(negedge clk);
    MEM_R_EN = 1'b0;
    #2 rst = 1'b1;
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'hCAFEBABE;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk("stray_ack_req", 32'(mem_req), 32'd0);
    chk("stray_ack_out", out, exp_out);
    chk("stray_ack_freeze", 32'(freeze), 32'd0);
    chk("rst_txns", 32'(req_count), 32'(base_cnt + 1));
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_master.md
Name: mem_access_master

Overview:
- Initiator-side load/store unit in the Memory stage.
- Turns the pipeline's read/write enables, ALU-computed byte address and store value into a request/acknowledge transaction toward a multi-cycle word-addressed data memory.
- Freezes the pipeline while the transaction is outstanding and returns registered load data to the write-back path.

Parameters:
- ADDRESS_LEN, 32, width of the pipeline byte address.
- WORD_LEN, 32, data word width.
- MEM_BASE, 1024, byte address mapped to memory word 0.
- MEMORY_SIZE, 64, number of words in the data memory.
- TIMEOUT, 15, maximum cycles spent in REQ waiting for mem_ack before aborting (1..255).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- MEM_R_EN  in  1  load request from pipeline.
- MEM_W_EN  in  1  store request from pipeline.
- ALU_Res  in  ADDRESS_LEN  byte address.
- Val_Rm  in  WORD_LEN  store data.
- freeze  out  1  stall request to all upstream pipeline registers.
- out  out  WORD_LEN  registered load data.
- access_err  out  1  illegal access or timeout indication.
- mem_req  out  1  request valid toward memory.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req.
- mem_addr  out  ADDRESS_LEN-2  word address; valid while mem_req.
- mem_wdata  out  WORD_LEN  write data; valid while mem_req.
- mem_ack  in  1  memory completion; one-cycle pulse.
- mem_rdata  in  WORD_LEN  read data; valid in the mem_ack cycle.

Behaviour:
- Reset (rst low, async): state=IDLE; mem_req, mem_we, mem_addr, mem_wdata, out and the timeout counter all 0. Reset mid-transaction abandons it; mem_req drops immediately.
- Address check: off = ALU_Res - MEM_BASE (modulo 2^ADDRESS_LEN).
  - Legal iff off[1:0]==0 and off[ADDRESS_LEN-1:2] < MEMORY_SIZE.
  - Word address = off[ADDRESS_LEN-1:2].
- Request kind: MEM_W_EN has priority. If MEM_R_EN and MEM_W_EN are both 1, the access is a write and access_err is asserted.
- IDLE, any enable, legal address:
  - Register mem_addr, mem_we and mem_wdata=Val_Rm.
  - Clear the counter and go to REQ.
  - freeze=1 combinationally in this cycle.
- IDLE, any enable, illegal address:
  - No request is issued; freeze=0; out is unchanged.
  - access_err=1 combinationally for as long as the condition holds, which is one cycle per instruction.
- REQ:
  - mem_req=1 and freeze=1; mem_addr, mem_we and mem_wdata are held stable.
  - On mem_ack: if a read, out <= mem_rdata. Go to DONE.
  - Otherwise the counter increments. When the counter reaches TIMEOUT: access_err pulses 1 for one cycle (registered), out is unchanged, go to DONE.
- DONE:
  - mem_req=0 and freeze=0 for exactly one cycle. The pipeline advances on this edge.
  - Next state is IDLE unconditionally. This prevents re-issue of the same instruction.
- mem_ack outside REQ is ignored.
- An ack in the first REQ cycle is legal.
- Minimum access: cycle 0 IDLE (freeze=1), cycle 1 REQ with ack (freeze=1), cycle 2 DONE (freeze=0). That is 2 stall cycles. Each extra wait cycle adds one.
- out holds its value until the next successful read.
- Stores never modify out.
- freeze never depends on mem_ack combinationally. There is no combinational path from mem_ack to freeze or mem_req.

Test Plan:
1. Read, 0-wait: ALU_Res=1032, MEM_R_EN=1, ack in the first REQ cycle with mem_rdata=0xDEADBEEF -> mem_addr=2, mem_we=0; freeze high 2 cycles; out=0xDEADBEEF in the DONE cycle.
2. Write, 3-wait: ALU_Res=1024, Val_Rm=-5, MEM_W_EN=1, ack on the 4th REQ cycle -> mem_addr=0, mem_we=1, mem_wdata=0xFFFFFFFB stable throughout; freeze high 5 cycles; out unchanged.
3. Illegal addresses -> access_err=1, mem_req never rises, freeze=0:
   - ALU_Res=1026 (misaligned).
   - ALU_Res=1024+4*64 (out of range).
   - ALU_Res=1000 (below base, wraps out of range).
4. Timeout: read at 1040, mem_ack held 0 -> after 15 REQ cycles access_err pulses once, then DONE, then IDLE; out retains its prior value.
5. Back-to-back: a read at 1028, then next instruction a write at 1036 presented right after DONE -> exactly two mem_req transactions; the DONE cycle separates them with mem_req=0; no duplicate request.
6. Reset mid-REQ: rst low asynchronously during the REQ wait -> mem_req and freeze drop without a clock edge; out=0; a stray mem_ack after reset release is ignored.
